// File: rtl/mac_2_3_stream_pkg.sv
// mac_2_3_stream_pkg: shared FSM state type and product width for the 2x3 MAC stream
package mac_2_3_stream_pkg;

    localparam int PROD_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/mac_2_3_stream_mult.sv
// Mult_2_3: combinational signed 2-bit x 3-bit multiplier
// Ports: a (signed 2b), b (signed 3b), p (signed 5b product)
module Mult_2_3
    import mac_2_3_stream_pkg::*;
(
    input  logic [1:0]        a,
    input  logic [2:0]        b,
    output logic [PROD_W-1:0] p
);

    // The low 5 bits of a product of sign-extended operands are the exact signed product.
    assign p = {{(PROD_W-2){a[1]}}, a} * {{(PROD_W-3){b[2]}}, b};

endmodule

// File: rtl/mac_2_3_stream.sv
// mac_2_3_stream: framed multiply-accumulate of signed 2b x 3b pairs with valid/ready handshakes
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_last operand stream;
//        out_valid/out_ready/out_acc/out_count/out_ovf per-frame result
module mac_2_3_stream
    import mac_2_3_stream_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [2:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [4:0]       out_count,
    output logic             out_ovf
);

    state_t            state_q, state_d;
    logic              p_valid_q, p_last_q, first_q, ovf_q, ovf_d;
    logic [1:0]        p_a_q;
    logic [2:0]        p_b_q;
    logic [4:0]        n_q, cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d, prod_x, sum;
    logic [PROD_W-1:0] prod;
    logic              accept, last_in, add_ovf;

    Mult_2_3 u_mult (.a(p_a_q), .b(p_b_q), .p(prod));

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_RUN);
    assign out_valid = (state_q == S_HOLD);
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign accept    = in_valid && in_ready;
    // n_q counts elements accepted so far in the open frame; the MAX_LEN-th closes it.
    assign last_in   = in_last || (n_q == 5'(MAX_LEN - 1));
    assign prod_x    = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum       = acc_q + prod_x;
    assign add_ovf   = (acc_q[ACC_W-1] == prod_x[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_RUN: state_d = accept ? (last_in ? S_DRAIN : S_RUN) : state_q;
            S_DRAIN:       state_d = (p_valid_q && p_last_q) ? S_HOLD : S_DRAIN;
            S_HOLD:        state_d = out_ready ? S_IDLE : S_HOLD;
            default:       state_d = S_IDLE;
        endcase
        if (p_valid_q) begin
            acc_d = first_q ? prod_x : sum;
            cnt_d = first_q ? 5'd1 : cnt_q + 5'd1;
            ovf_d = !first_q && (ovf_q || add_ovf);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            p_valid_q <= 1'b0;
            p_a_q     <= '0;
            p_b_q     <= '0;
            p_last_q  <= 1'b0;
            n_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            p_valid_q <= accept;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            if (accept) begin
                p_a_q    <= in_a;
                p_b_q    <= in_b;
                p_last_q <= last_in;
                n_q      <= last_in ? 5'd0 : n_q + 5'd1;
            end
            // The next accumulated element after a result handshake starts a fresh frame.
            if (p_valid_q)
                first_q <= 1'b0;
            else if (out_valid && out_ready)
                first_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_2_3_stream.sv
// tb_mac_2_3_stream: directed self-checking bench for mac_2_3_stream (ACC_W=12 and ACC_W=6 instances)
module tb_mac_2_3_stream;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_last = 0, out_ready = 0;
    logic [1:0]  in_a = 0;
    logic [2:0]  in_b = 0;
    logic        in_ready, out_valid, out_ovf, in_ready6, out_valid6, out_ovf6;
    logic [11:0] out_acc;
    logic [5:0]  out_acc6;
    logic [4:0]  out_count, out_count6;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mac_2_3_stream #(.ACC_W(12), .MAX_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    mac_2_3_stream #(.ACC_W(6), .MAX_LEN(16)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid6),
        .out_ready(out_ready), .out_acc(out_acc6), .out_count(out_count6), .out_ovf(out_ovf6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [2:0] b, input logic l);
        check("push_ready", in_ready, 1);
        in_valid = 1; in_a = a; in_b = b; in_last = l;
        @(posedge clk); #1;
        in_valid = 0; in_a = 0; in_b = 0; in_last = 0;
    endtask

    // Called right after the last accept: checks 2-cycle latency, the result, then pops it.
    task automatic frame_done(input string tag, input logic [11:0] ea, input logic [4:0] ec,
                              input logic eo, input logic [5:0] ea6, input logic eo6);
        check({tag, "_busy"}, in_ready, 0);
        check({tag, "_early"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_valid6"}, out_valid6, 1);
        check({tag, "_acc"}, out_acc, ea);
        check({tag, "_cnt"}, out_count, ec);
        check({tag, "_ovf"}, out_ovf, eo);
        check({tag, "_acc6"}, out_acc6, ea6);
        check({tag, "_ovf6"}, out_ovf6, eo6);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, "_pop"}, out_valid, 0);
        check({tag, "_rdy"}, in_ready, 1);
    endtask

    initial begin
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_acc", out_acc, 0);
        check("rst_cnt", out_count, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        push(2'd1, 3'd3, 1);
        frame_done("single", 12'd3, 5'd1, 0, 6'd3, 0);

        push(2'd1, 3'd3, 0);
        push(2'b10, 3'b100, 0);
        push(2'b11, 3'b010, 0);
        push(2'b00, 3'b011, 1);
        check("four_busy", in_ready, 0);
        @(posedge clk); #1;
        check("four_valid", out_valid, 1);
        check("four_acc", out_acc, 12'd9);
        check("four_cnt", out_count, 5'd4);
        in_valid = 1; in_a = 2'd1; in_b = 3'd1; in_last = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_acc", out_acc, 12'd9);
            check("bp_cnt", out_count, 5'd4);
            check("bp_ovf", out_ovf, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("bp_pop", out_valid, 0);
        check("bp_rdy", in_ready, 1);
        @(posedge clk); #1;
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_cnt", out_count, 5'd4);

        for (int i = 0; i < 4; i++) push(2'b10, 3'b100, i == 3);
        frame_done("ovf", 12'd32, 5'd4, 0, 6'h20, 1);

        for (int i = 0; i < 16; i++) push(2'd1, 3'd1, 0);
        frame_done("force", 12'd16, 5'd16, 0, 6'd16, 0);
        push(2'd1, 3'd1, 1);
        frame_done("after_force", 12'd1, 5'd1, 0, 6'd1, 0);

        push(2'd1, 3'd1, 0);
        push(2'd1, 3'd1, 0);
        rst_n = 0; #2;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_acc", out_acc, 0);
        check("mid_rst_cnt", out_count, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_still_idle", out_valid, 0);
        push(2'd1, 3'd1, 1);
        frame_done("post_rst", 12'd1, 5'd1, 0, 6'd1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
